split_range_checker: RTL

//  Sequential, parametrised successor of the all-true constraint split blocks.

---
 rtl/split_range_checker.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/split_range_checker.sv
// Streams NUM_VARS operands per frame, checks each against its own [lo,hi] range and emits one verdict.
// Optional frame-sum limit check is compiled in when SPLIT_SUM_CHECK_EN is defined.
module split_range_checker #(
  parameter int NUM_VARS  = 50,
  parameter int DATA_W    = 16,
  parameter int SUM_LIMIT = 65535
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  output logic                        busy,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           in_data,
  input  logic                        in_last,
  input  logic                        cfg_we,
  input  logic [$clog2(NUM_VARS)-1:0] cfg_idx,
  input  logic [DATA_W-1:0]           cfg_lo,
  input  logic [DATA_W-1:0]           cfg_hi,
  output logic                        x,
  output logic                        x_valid,
  output logic                        frame_err
);
  localparam int IDX_W = $clog2(NUM_VARS);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_EVAL, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              pass_q, pass_d;
  logic              frame_err_q, frame_err_d;
  logic              verdict_q, verdict_d;
  logic              x_q, x_d;
  logic              x_valid_q, x_valid_d;
  logic [DATA_W-1:0] lo_q [NUM_VARS];
  logic [DATA_W-1:0] lo_d [NUM_VARS];
  logic [DATA_W-1:0] hi_q [NUM_VARS];
  logic [DATA_W-1:0] hi_d [NUM_VARS];
  logic              last_idx;
  logic              sum_ok;

  function automatic logic in_range(input logic [DATA_W-1:0] v,
                                    input logic [DATA_W-1:0] lo,
                                    input logic [DATA_W-1:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

`ifdef SPLIT_SUM_CHECK_EN
  // Wide enough for NUM_VARS full-scale operands, so the sum never wraps.
  localparam int SUM_W = DATA_W + IDX_W;
  logic [SUM_W-1:0] sum_q, sum_d;
  assign sum_ok = (longint'(sum_q) <= longint'(SUM_LIMIT));
`else
  assign sum_ok = 1'b1;
`endif

  assign last_idx = (idx_q == IDX_W'(NUM_VARS - 1));

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    pass_d      = pass_q;
    frame_err_d = frame_err_q;
    verdict_d   = verdict_q;
    x_d         = x_q;
    x_valid_d   = 1'b0;
    lo_d        = lo_q;
    hi_d        = hi_q;
`ifdef SPLIT_SUM_CHECK_EN
    sum_d       = sum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cfg_we && (int'(cfg_idx) < NUM_VARS)) begin
          lo_d[cfg_idx] = cfg_lo;
          hi_d[cfg_idx] = cfg_hi;
        end
        if (start) begin
          state_d     = S_COLLECT;
          idx_d       = '0;
          pass_d      = 1'b1;
          frame_err_d = 1'b0;
`ifdef SPLIT_SUM_CHECK_EN
          sum_d       = '0;
`endif
        end
      end
      S_COLLECT: begin
        if (in_valid) begin
          pass_d = pass_q & in_range(in_data, lo_q[idx_q], hi_q[idx_q]);
          idx_d  = idx_q + IDX_W'(1);
`ifdef SPLIT_SUM_CHECK_EN
          sum_d  = sum_q + SUM_W'(in_data);
`endif
          // Early in_last and a missing in_last on the final slot both end the frame as an error.
          if (in_last != last_idx) frame_err_d = 1'b1;
          if (in_last || last_idx) state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        verdict_d = pass_q & ~frame_err_q & sum_ok;
        state_d   = S_DONE;
      end
      S_DONE: begin
        x_d       = verdict_q;
        x_valid_d = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      pass_q      <= 1'b1;
      frame_err_q <= 1'b0;
      verdict_q   <= 1'b1;
      x_q         <= 1'b1;
      x_valid_q   <= 1'b0;
      for (int i = 0; i < NUM_VARS; i++) begin
        lo_q[i] <= '0;
        hi_q[i] <= '1;
      end
`ifdef SPLIT_SUM_CHECK_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      pass_q      <= pass_d;
      frame_err_q <= frame_err_d;
      verdict_q   <= verdict_d;
      x_q         <= x_d;
      x_valid_q   <= x_valid_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
`ifdef SPLIT_SUM_CHECK_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign in_ready  = (state_q == S_COLLECT);
  assign x         = x_q;
  assign x_valid   = x_valid_q;
  assign frame_err = frame_err_q;

endmodule
